// File: rtl/apb_global_pkg.sv
// rtl/apb_global_pkg.sv - shared state/transfer types, command struct and default sizing for the APB master bridge
package apb_global_pkg;

  localparam int unsigned ADDR_MAX_W      = 32;
  localparam int unsigned DATA_MAX_W      = 32;
  localparam int unsigned SLAVE_ADDR_BITS = 8;
  localparam int unsigned MAX_WAIT        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } operation_states_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  // Held at the widest legal size; the bridge slices down to its configured widths.
  typedef struct packed {
    tx_type_e                  write;
    logic [ADDR_MAX_W-1:0]     addr;
    logic [DATA_MAX_W-1:0]     wdata;
    logic [DATA_MAX_W/8-1:0]   strb;
    logic [2:0]                prot;
  } apb_cmd_s;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps an address to a one-hot completer select; flags addresses beyond the last completer
module apb_addr_decoder #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned NO_OF_SLAVES    = 3,
  parameter int unsigned SLAVE_ADDR_BITS = 8
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  output logic [NO_OF_SLAVES-1:0]  sel_o,
  output logic                     decode_err_o
);

  logic [ADDRESS_WIDTH-1:0] idx;

  assign idx = addr_i >> SLAVE_ADDR_BITS;

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      sel_o[i] = (idx == ADDRESS_WIDTH'(i));
    end
  end

  assign decode_err_o = ~|sel_o;

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB4 requester turning valid/ready commands into APB transfers to NO_OF_SLAVES completers
// Optional APB_TIMEOUT_EN: abort an ACCESS phase that has waited MAX_WAIT cycles and flag rsp_timeout.
import apb_global_pkg::*;

module apb_master_bridge #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NO_OF_SLAVES    = 3,
  parameter int unsigned SLAVE_ADDR_BITS = apb_global_pkg::SLAVE_ADDR_BITS,
  parameter int unsigned MAX_WAIT        = apb_global_pkg::MAX_WAIT
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic [NO_OF_SLAVES-1:0]   pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  operation_states_e         state_q, state_d;
  apb_cmd_s                  cmd_q, cmd_d;
  logic [NO_OF_SLAVES-1:0]   sel_q, sel_d, dec_sel;
  logic                      dec_err;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_slverr_q, rsp_slverr_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                      pend_q, pend_d;
  logic                      ready_c;
  logic                      accept;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_timeout_q, rsp_timeout_d;
`endif

  apb_addr_decoder #(
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .NO_OF_SLAVES    (NO_OF_SLAVES),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
  ) u_decoder (
    .addr_i       (cmd_addr),
    .sel_o        (dec_sel),
    .decode_err_o (dec_err)
  );

  assign cmd_ready = ready_c & ~preset;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    sel_d        = sel_q;
    pend_d       = 1'b0;
    ready_c      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_slverr_d = 1'b0;
    rsp_rdata_d  = '0;
`ifdef APB_TIMEOUT_EN
    wait_d        = wait_q;
    rsp_timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A decode error accepted during the previous completion is answered here.
        ready_c = ~pend_q;
        if (pend_q) begin
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          ready_c      = 1'b1;
          state_d      = IDLE;
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = pslverr;
          rsp_rdata_d  = (cmd_q.write == WRITE || pslverr) ? '0 : prdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (dec_err) begin
        if (state_q == ACCESS) begin
          pend_d = 1'b1;
        end else begin
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = 1'b1;
          rsp_rdata_d  = '0;
        end
      end else begin
        state_d     = SETUP;
        sel_d       = dec_sel;
        cmd_d.write = tx_type_e'(cmd_write);
        cmd_d.addr  = ADDR_MAX_W'(cmd_addr);
        cmd_d.prot  = cmd_prot;
        cmd_d.wdata = cmd_write ? DATA_MAX_W'(cmd_wdata) : '0;
        cmd_d.strb  = cmd_write ? (DATA_MAX_W/8)'(cmd_strb) : '0;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      sel_q        <= '0;
      pend_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_slverr_q <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_slverr_q <= rsp_slverr_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_q        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign pselx      = (state_q == IDLE) ? '0 : sel_q;
  assign penable    = (state_q == ACCESS);
  assign pwrite     = (cmd_q.write == WRITE);
  assign paddr      = cmd_q.addr[ADDRESS_WIDTH-1:0];
  assign pwdata     = cmd_q.wdata[DATA_WIDTH-1:0];
  assign pstrb      = cmd_q.strb[DATA_WIDTH/8-1:0];
  assign pprot      = cmd_q.prot;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_slverr = rsp_slverr_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [2:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .ADDRESS_WIDTH   (32),
    .DATA_WIDTH      (32),
    .NO_OF_SLAVES    (3),
    .SLAVE_ADDR_BITS (8),
    .MAX_WAIT        (4)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  task automatic test_reset();
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #3;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, pselx, penable, pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b sel=%b en=%b addr=%h want all zero", cmd_ready, rsp_valid, pselx, penable, paddr);
    end
    cyc(); cyc();
    preset = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, pselx, penable, rsp_valid} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b sel=%b en=%b rv=%b want rdy=1 sel=000 en=0 rv=0", cmd_ready, pselx, penable, rsp_valid);
    end
  endtask

  task automatic test_write();
    cyc();
    send(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 3'b010);
    prdata = 32'hFFFF_0000; pready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", cmd_ready); end
    cyc(); cmd_valid = 1'b0;
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid} !== {3'b010, 1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b0}) begin
      errors++;
      $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wd=%h st=%h pr=%b rv=%b want 010 0 1 104 deadbeef f 010 0",
               pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid);
    end
    cyc();
    checks++;
    if ({pselx, penable, paddr, pwdata, cmd_ready, rsp_valid} !== {3'b010, 1'b1, 32'h104, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_access: got sel=%b en=%b addr=%h wd=%h rdy=%b rv=%b want 010 1 104 deadbeef 1 0", pselx, penable, paddr, pwdata, cmd_ready, rsp_valid);
    end
    cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_rdata, pselx, penable, paddr, pwrite} !== {1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 32'h104, 1'b1}) begin
      errors++;
      $display("FAIL wr_rsp: got rv=%b err=%b rd=%h sel=%b en=%b addr=%h wr=%b want 1 0 0 000 0 104 1", rsp_valid, rsp_slverr, rsp_rdata, pselx, penable, paddr, pwrite);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL wr_rsp_pulse: got rv=%b rd=%h want 0 0", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_read_wait();
    cyc();
    send(1'b0, 32'h0000_0208, 32'hCAFE_F00D, 4'hF, 3'b000);
    pready = 1'b0; prdata = 32'h1234_5678;
    cyc(); cmd_valid = 1'b0;
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata, pstrb} !== {3'b100, 1'b0, 1'b0, 32'h208, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL rd_setup: got sel=%b en=%b wr=%b addr=%h wd=%h st=%h want 100 0 0 208 0 0", pselx, penable, pwrite, paddr, pwdata, pstrb);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({pselx, penable, cmd_ready, rsp_valid, pstrb} !== {3'b100, 1'b1, 1'b0, 1'b0, 4'h0}) begin
        errors++;
        $display("FAIL rd_wait%0d: got sel=%b en=%b rdy=%b rv=%b st=%h want 100 1 0 0 0", i, pselx, penable, cmd_ready, rsp_valid, pstrb);
      end
    end
    cyc(); pready = 1'b1; #1;
    checks++;
    if ({penable, cmd_ready, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL rd_ready_cycle: got en=%b rdy=%b rv=%b want 1 1 0", penable, cmd_ready, rsp_valid);
    end
    cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_rdata, pselx, penable} !== {1'b1, 1'b0, 32'h1234_5678, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp: got rv=%b err=%b rd=%h sel=%b en=%b want 1 0 12345678 000 0", rsp_valid, rsp_slverr, rsp_rdata, pselx, penable);
    end
  endtask

  task automatic test_decode_err();
    cyc();
    send(1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'b000);
    prdata = 32'hBAD0_BAD0; pready = 1'b1;
    cyc(); cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_rdata, pselx, penable, cmd_ready} !== {1'b1, 1'b1, 32'h0, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dec_rsp: got rv=%b err=%b rd=%h sel=%b en=%b rdy=%b want 1 1 0 000 0 1", rsp_valid, rsp_slverr, rsp_rdata, pselx, penable, cmd_ready);
    end
    cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, pselx, penable} !== 6'b0) begin
      errors++;
      $display("FAIL dec_after: got rv=%b err=%b sel=%b en=%b want 0 0 000 0", rsp_valid, rsp_slverr, pselx, penable);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    send(1'b1, 32'h0000_0010, 32'h1122_3344, 4'h3, 3'b001);
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    cyc();
    checks++;
    if ({pselx, penable, pstrb, cmd_ready} !== {3'b001, 1'b0, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL b2b_setup1: got sel=%b en=%b st=%h rdy=%b want 001 0 3 0", pselx, penable, pstrb, cmd_ready);
    end
    send(1'b0, 32'h0000_0220, 32'h0, 4'hF, 3'b100);
    cyc();
    checks++;
    if ({pselx, penable, paddr, cmd_ready} !== {3'b001, 1'b1, 32'h10, 1'b1}) begin
      errors++;
      $display("FAIL b2b_access1: got sel=%b en=%b addr=%h rdy=%b want 001 1 10 1", pselx, penable, paddr, cmd_ready);
    end
    cyc();
    cmd_valid = 1'b0; prdata = 32'hA5A5_0001; pslverr = 1'b1;
    checks++;
    if ({pselx, penable, paddr, pwrite, pprot, pstrb, rsp_valid, rsp_slverr, rsp_rdata} !== {3'b100, 1'b0, 32'h220, 1'b0, 3'b100, 4'h0, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL b2b_setup2: got sel=%b en=%b addr=%h wr=%b pr=%b st=%h rv=%b err=%b rd=%h want 100 0 220 0 100 0 1 0 0",
               pselx, penable, paddr, pwrite, pprot, pstrb, rsp_valid, rsp_slverr, rsp_rdata);
    end
    cyc();
    checks++;
    if ({pselx, penable, rsp_valid} !== {3'b100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_access2: got sel=%b en=%b rv=%b want 100 1 0", pselx, penable, rsp_valid);
    end
    cyc(); pready = 1'b0; pslverr = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_rdata, pselx, penable} !== {1'b1, 1'b1, 32'h0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL b2b_rsp2: got rv=%b err=%b rd=%h sel=%b en=%b want 1 1 0 000 0", rsp_valid, rsp_slverr, rsp_rdata, pselx, penable);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    send(1'b1, 32'h0000_0104, 32'h0000_0005, 4'h1, 3'b000);
    pready = 1'b0;
    cyc(); cmd_valid = 1'b0;
    cyc();
    checks++;
    if (penable !== 1'b1) begin errors++; $display("FAIL rst_mid_access: got en=%b want 1", penable); end
    preset = 1'b1; pready = 1'b1;
    #1;
    checks++;
    if ({pselx, penable, rsp_valid, cmd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: got sel=%b en=%b rv=%b rdy=%b want 000 0 0 0", pselx, penable, rsp_valid, cmd_ready);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_norsp1: got rv=%b want 0", rsp_valid); end
    preset = 1'b0;
    cyc();
    checks++;
    if ({rsp_valid, pselx, cmd_ready} !== {1'b0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_norsp2: got rv=%b sel=%b rdy=%b want 0 000 1", rsp_valid, pselx, cmd_ready);
    end
    send(1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000);
    prdata = 32'h0000_55AA;
    cyc(); cmd_valid = 1'b0;
    checks++;
    if ({pselx, penable} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_next_setup: got sel=%b en=%b want 001 0", pselx, penable);
    end
    cyc(); cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_55AA}) begin
      errors++;
      $display("FAIL rst_mid_next_rsp: got rv=%b err=%b rd=%h want 1 0 55aa", rsp_valid, rsp_slverr, rsp_rdata);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    cyc();
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000);
    pready = 1'b0; prdata = 32'h7777_7777;
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({penable, rsp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL to_wait%0d: got en=%b rv=%b want 1 0", i, penable, rsp_valid);
      end
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, pselx, penable} !== {1'b1, 1'b1, 1'b1, 32'h0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL to_abort: got rv=%b err=%b to=%b rd=%h sel=%b en=%b want 1 1 1 0 000 0", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, pselx, penable);
    end
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000);
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    pready = 1'b1;
    cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h7777_7777}) begin
      errors++;
      $display("FAIL to_boundary: got rv=%b err=%b to=%b rd=%h want 1 0 0 77777777", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata);
    end
  endtask
`else
  task automatic test_long_wait();
    cyc();
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000);
    pready = 1'b0; prdata = 32'h0000_0009;
    cyc(); cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({pselx, penable, rsp_valid} !== {3'b010, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL long_wait%0d: got sel=%b en=%b rv=%b want 010 1 0", i, pselx, penable, rsp_valid);
      end
    end
    pready = 1'b1;
    cyc(); pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h9}) begin
      errors++;
      $display("FAIL long_wait_rsp: got rv=%b err=%b to=%b rd=%h want 1 0 0 9", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Parametrised APB4 requester. Converts a valid/ready command interface into APB transfers to NO_OF_SLAVES completers.
- Decodes the slave from the address and drives a one-hot pselx.
- Runs the IDLE/SETUP/ACCESS protocol with pready wait states and returns a single-cycle response carrying read data and pslverr.
- Sits between on-chip command sources and the APB fabric exercised by the APB AVIP agents.

Parameters:
- ADDRESS_WIDTH, 32, paddr width (max 32).
- DATA_WIDTH, 32, pwdata/prdata width (8, 16 or 32).
- NO_OF_SLAVES, 3, number of completers, width of pselx (1..16).
- SLAVE_ADDR_BITS, 8, log2 of each slave's address window; slave index = addr[ADDRESS_WIDTH-1:SLAVE_ADDR_BITS].
- MAX_WAIT, 16, ACCESS wait cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=WRITE, 0=READ
- cmd_addr  in  ADDRESS_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_slverr  out  1  completer error, decode error or timeout
- rsp_timeout  out  1  abort due to timeout (tied 0 without macro)
- pselx  out  NO_OF_SLAVES  one-hot select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDRESS_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- pprot  out  3  APB protection
- pready  in  1  completer ready
- prdata  in  DATA_WIDTH  completer read data
- pslverr  in  1  completer error

Behaviour:
- Reset: all outputs 0; state IDLE. Reset asserted mid-transfer drops pselx/penable immediately (asynchronous). No response is issued for the aborted transfer.
- States: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
- cmd_ready is high in IDLE. It is also high in ACCESS during the cycle pready=1. It is low otherwise.
- Accept (edge k), valid decode: latch the command and go to SETUP.
  - SETUP (cycle k+1): pselx[idx]=1, penable=0, paddr/pwrite/pprot driven.
  - For writes: pwdata=cmd_wdata, pstrb=cmd_strb.
  - For reads: pwdata=0, pstrb=0.
- SETUP -> ACCESS unconditionally: penable=1; all APB outputs held stable.
- ACCESS, pready=0: stay in ACCESS (wait state).
- ACCESS, pready=1: capture prdata (reads only) and pslverr.
  - rsp_valid pulses the next cycle.
  - Zero-wait latency: accept edge k, rsp_valid high in cycle k+3.
  - If a command is accepted in the same cycle: go straight to SETUP with penable=0 and the new pselx; no IDLE bubble.
  - Otherwise go to IDLE: pselx=0, penable=0.
- Decode error (idx >= NO_OF_SLAVES):
  - No APB activity; pselx stays 0.
  - rsp_valid with rsp_slverr=1 and rsp_rdata=0 the cycle after accept.
  - State remains IDLE and cmd_ready stays high.
- No response backpressure: rsp_* are valid only while rsp_valid=1 and are 0 otherwise.
- paddr, pwrite and pprot retain their last values in IDLE.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches MAX_WAIT with pready still 0: drop pselx/penable, go to IDLE, and pulse rsp_valid next cycle with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the same cycle the count reaches MAX_WAIT completes the transfer normally.
- Undefined: no counter; waits indefinitely; rsp_timeout tied 0.

Decomposition:
- apb_global_pkg holds shared types:
  - operation_states_e (state encoding)
  - tx_type_e (cmd_write meaning)
  - a new apb_cmd_s struct: write, addr, wdata, strb, prot
  - new parameters SLAVE_ADDR_BITS and MAX_WAIT
- One combinational sub-module, apb_addr_decoder: address in; one-hot select and decode_err out.

Test Plan:
- Write 0x0000_0104, data 0xDEAD_BEEF, strb 0xF, pready=1 -> SETUP pselx=3'b010 penable=0; ACCESS penable=1; rsp_valid at k+3, slverr=0, rdata=0.
- Read 0x0000_0208, pready low 2 cycles, prdata 0x1234_5678 -> ACCESS held 3 cycles, pstrb=0, rsp_rdata=0x1234_5678 at k+5.
- Read 0x0000_0300 -> pselx stays 3'b000; rsp_valid at k+1 with slverr=1, rdata=0.
- Back-to-back write 0x0000_0010 then read 0x0000_0220, cmd_valid held high -> second SETUP directly after first ACCESS; pselx 3'b001 -> 3'b100; no IDLE cycle.
- Assert preset during ACCESS -> pselx, penable and rsp_valid are 0 the same cycle; no response issued; after release, next command runs normally.
- APB_TIMEOUT_EN, MAX_WAIT=4, pready held 0 -> abort after 4 wait cycles; rsp_valid with slverr=1, rsp_timeout=1; pselx=0.
